// File: rtl/chacha_pkg.sv
// chacha_pkg: shared defaults and FSM state type for the keystream stream decryptor.
package chacha_pkg;
    localparam int DATA_SIZE_DEF    = 8;
    localparam int NUM_MATRICES_DEF = 3;
    localparam int NO_REG_DEF       = 64 * NUM_MATRICES_DEF;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } dec_state_t;
endpackage

// File: rtl/stream_decryptor_if.sv
// stream_decryptor_if: control, keystream, ciphertext and plaintext channels of the decryptor.
interface stream_decryptor_if
    import chacha_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int NO_REG    = NO_REG_DEF
) ();
    logic                 start;
    logic                 ks_req;
    logic                 ks_valid;
    logic [DATA_SIZE-1:0] ks_in [0:NO_REG-1];
    logic                 ct_valid;
    logic [DATA_SIZE-1:0] ct_data;
    logic                 ct_last;
    logic                 ct_ready;
    logic                 pt_valid;
    logic [DATA_SIZE-1:0] pt_data;
    logic                 pt_last;
    logic                 pt_ready;
    logic [31:0]          blk_cnt;
    logic                 done;
    modport master (
        output start, ks_valid, ks_in, ct_valid, ct_data, ct_last, pt_ready,
        input  ks_req, ct_ready, pt_valid, pt_data, pt_last, blk_cnt, done
    );
    modport slave (
        input  start, ks_valid, ks_in, ct_valid, ct_data, ct_last, pt_ready,
        output ks_req, ct_ready, pt_valid, pt_data, pt_last, blk_cnt, done
    );
endinterface

// File: rtl/stream_decryptor.sv
// stream_decryptor: XORs a ciphertext byte stream with keystream blocks fetched on demand.
// Define STREAM_DECRYPTOR_ZEROIZE_EN to wipe the keystream buffer on reset and at message end.
module stream_decryptor
    import chacha_pkg::*;
#(
    parameter int DATA_SIZE    = DATA_SIZE_DEF,
    parameter int NUM_MATRICES = NUM_MATRICES_DEF,
    parameter int NO_REG       = 64 * NUM_MATRICES
) (
    input  logic              clk,
    input  logic              rst,
    stream_decryptor_if.slave bus
);
    localparam int IW = (NO_REG > 1) ? $clog2(NO_REG) : 1;

    dec_state_t           r_state;
    dec_state_t           w_next;
    logic [DATA_SIZE-1:0] r_buf [0:NO_REG-1];
    logic [IW-1:0]        r_idx;
    logic [31:0]          r_blk_cnt;
    logic                 r_pt_valid;
    logic [DATA_SIZE-1:0] r_pt_data;
    logic                 r_pt_last;
    logic                 r_done;
    logic                 w_load;
    logic                 w_accept;
    logic                 w_take;
    logic                 w_idx_end;

    assign w_load    = (r_state == REQ) && bus.ks_valid;
    assign w_accept  = bus.ct_valid && bus.ct_ready;
    assign w_take    = r_pt_valid && bus.pt_ready;
    assign w_idx_end = r_idx == IW'(NO_REG - 1);

    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end

    // A last byte always ends the message, even when it also exhausts the block.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? REQ : IDLE;
            REQ:     w_next = bus.ks_valid ? STREAM : REQ;
            STREAM:  w_next = !w_accept ? STREAM : bus.ct_last ? DRAIN : w_idx_end ? REQ : STREAM;
            DRAIN:   w_next = w_take ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ks_req   = r_state == REQ;
        bus.ct_ready = (r_state == STREAM) && (!r_pt_valid || bus.pt_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_blk_cnt  <= '0;
            r_pt_valid <= 1'b0;
            r_pt_data  <= '0;
            r_pt_last  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == DRAIN) && w_take;
            if (r_state == IDLE && bus.start)
                r_blk_cnt <= '0;
            else if (w_load)
                r_blk_cnt <= r_blk_cnt + 32'd1;
            if (w_load)
                r_idx <= '0;
            else if (w_accept)
                r_idx <= w_idx_end ? '0 : r_idx + IW'(1);
            if (w_accept) begin
                r_pt_valid <= 1'b1;
                r_pt_data  <= bus.ct_data ^ r_buf[r_idx];
                r_pt_last  <= bus.ct_last;
            end else if (bus.pt_ready) begin
                r_pt_valid <= 1'b0;
            end
        end
    end

`ifdef STREAM_DECRYPTOR_ZEROIZE_EN
    always_ff @(posedge clk) begin
        if (rst || (r_state == DRAIN && w_take))
            r_buf <= '{default: '0};
        else if (w_load)
            r_buf <= bus.ks_in;
    end
`else
    always_ff @(posedge clk) begin
        if (!rst && w_load)
            r_buf <= bus.ks_in;
    end
`endif

    assign bus.pt_valid = r_pt_valid;
    assign bus.pt_data  = r_pt_data;
    assign bus.pt_last  = r_pt_last;
    assign bus.blk_cnt  = r_blk_cnt;
    assign bus.done     = r_done;
endmodule

// File: doc/stream_decryptor.md
STREAM_DECRYPTOR -- requirements
Module: stream_decryptor

Interface
REQ-001 Parameter DATA_SIZE, default 8, SHALL set the width in bits of one keystream, ciphertext and plaintext byte.
REQ-002 Parameter NUM_MATRICES, default 3, SHALL set the number of 64-byte keystream matrices per keystream block.
REQ-003 Parameter NO_REG, default 64*NUM_MATRICES, SHALL set the number of bytes per keystream block.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle pulse that begins a message decrypt.
REQ-008 ks_req  out  1  requests the next keystream block.
REQ-009 ks_valid  in  1  ks_in holds a valid keystream block.
REQ-010 ks_in  in  DATA_SIZE x NO_REG (unpacked [0:NO_REG-1])  keystream block.
REQ-011 ct_valid / ct_data (DATA_SIZE) / ct_last  in  1/DATA_SIZE/1  ciphertext byte stream; ct_last marks the final byte.
REQ-012 ct_ready  out  1  ciphertext byte accepted when ct_valid && ct_ready.
REQ-013 pt_valid / pt_data (DATA_SIZE) / pt_last  out  1/DATA_SIZE/1  plaintext byte stream.
REQ-014 pt_ready  in  1  downstream accepts the plaintext byte.
REQ-015 blk_cnt  out  32  count of keystream blocks loaded since the last start.
REQ-016 done  out  1  one-cycle pulse when the last plaintext byte is taken.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, STREAM and DRAIN.
REQ-018 In IDLE, start SHALL move the FSM to REQ and clear blk_cnt to 0; in all other states, start SHALL be ignored.
REQ-019 In REQ, ks_req SHALL be 1; on ks_valid, the block SHALL capture ks_in into an internal buffer, set the byte index to 0, increment blk_cnt, and go to STREAM.
REQ-020 Outside REQ, ks_req SHALL be 0 and ks_valid SHALL be ignored.
REQ-021 ct_ready SHALL be 1 only in STREAM and only when (!pt_valid || pt_ready).
REQ-022 On each accepted byte, the block SHALL register pt_data = ct_data ^ buf[idx] and pt_last = ct_last, set pt_valid the next cycle (latency 1), and increment idx.
REQ-023 pt_valid SHALL hold, with pt_data and pt_last stable, until pt_ready; the block SHALL sustain one byte per cycle when pt_ready is held at 1.
REQ-024 If the accepted byte has idx == NO_REG-1 and ct_last == 0, the FSM SHALL go to REQ (keystream wrap).
REQ-025 If the accepted byte has ct_last == 1, the FSM SHALL go to DRAIN; this takes priority over the wrap, so no new block is requested.
REQ-026 In DRAIN, the FSM SHALL go to IDLE and pulse done for one cycle when pt_valid && pt_ready.
REQ-027 In REQ, the output register SHALL still drain to the consumer while new keystream is awaited.

Reset
REQ-028 On rst, the FSM SHALL enter IDLE, and the outputs SHALL take these values: ks_req=0, ct_ready=0, pt_valid=0, pt_data=0, pt_last=0, blk_cnt=0, done=0, idx=0.
REQ-029 An rst in any state SHALL abort the message without emitting a further pt_valid, and SHALL take priority over every other input.

Configuration
REQ-030 With macro STREAM_DECRYPTOR_ZEROIZE_EN defined, the keystream buffer SHALL be cleared to all zeros on rst and on the DRAIN->IDLE transition.
REQ-031 Without STREAM_DECRYPTOR_ZEROIZE_EN, the buffer SHALL have no reset and SHALL keep its contents, and the remaining behaviour SHALL be unchanged.

Structure
REQ-032 Shared package chacha_pkg SHALL hold the DATA_SIZE, NUM_MATRICES and NO_REG defaults and the state enum typedef dec_state_t.
REQ-033 The block SHALL have no sub-module; the keystream buffer, index counter and FSM SHALL be inline.

Verification
REQ-034 rst, then start, then ks_in all bytes 0xA5, then 3 bytes 0x00,0xFF,0x5A with the last one flagged -> pt 0xA5,0x5A,0xFF, pt_last on the third, done one cycle after the handshake, blk_cnt=1.
REQ-035 NUM_MATRICES=1, 65-byte message, ks block0 = byte index, block1 = 0x11 -> ks_req reasserts after byte 63; byte 64 is XORed with 0x11; blk_cnt=2.
REQ-036 64-byte message ending exactly at idx 63 with ct_last -> no ks_req after the last byte; DRAIN, done; blk_cnt=1.
REQ-037 pt_ready toggled 1,0,0,1 during the stream -> ct_ready drops while pt_valid && !pt_ready; no byte lost or duplicated; order preserved.
REQ-038 rst asserted in STREAM after 10 bytes -> next cycle all outputs at reset values; a new start decrypts cleanly with blk_cnt restarting at 1.
REQ-039 With STREAM_DECRYPTOR_ZEROIZE_EN, after done, probing the buffer -> all zeros; start plus a fresh block decrypts correctly.
